// File: rtl/pwm_capture.sv
// pwm_capture: PWM high-time/period/duty meter; PWM_CAPTURE_TIMEOUT_EN adds stuck-input detection
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             enable,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [7:0]       duty,
  output logic             valid
`ifdef PWM_CAPTURE_TIMEOUT_EN
  ,
  output logic             stuck_high,
  output logic             stuck_low
`endif
);
  typedef enum logic [1:0] {IDLE, SYNC, HIGH, LOW} state_t;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic dly_q;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, pcnt_q, pcnt_d, oph_q, oph_d, opp_q, opp_d;
  logic [CNT_W-1:0] high_q, high_d, period_q, period_d;
  logic [CNT_W:0] rem_q, rem_d, rem2;
  logic [7:0] quo_q, quo_d, duty_q, duty_d;
  logic [2:0] step_q, step_d;
  logic busy_q, busy_d, valid_q, valid_d, ge, rise, fall;
`ifdef PWM_CAPTURE_TIMEOUT_EN
  localparam int T_W = $clog2(TIMEOUT + 1);
  logic [T_W-1:0] tcnt_q, tcnt_d;
  logic sh_q, sh_d, sl_q, sl_d, hit;
  assign stuck_high = sh_q;
  assign stuck_low  = sl_q;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return &x ? x : x + ONE;
  endfunction

  assign rise       = sync_q[1] & ~dly_q;
  assign fall       = ~sync_q[1] & dly_q;
  assign rem2       = rem_q << 1;
  assign ge         = rem2 >= {1'b0, opp_q};
  assign high_cnt   = high_q;
  assign period_cnt = period_q;
  assign duty       = duty_q;
  assign valid      = valid_q;

  // State, synchronizer, counters and divider registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      dly_q    <= 1'b0;
      hcnt_q   <= '0;
      pcnt_q   <= '0;
      oph_q    <= '0;
      opp_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      step_q   <= '0;
      busy_q   <= 1'b0;
      high_q   <= '0;
      period_q <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
`ifdef PWM_CAPTURE_TIMEOUT_EN
      tcnt_q   <= '0;
      sh_q     <= 1'b0;
      sl_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[0], pwm_in};
      dly_q    <= sync_q[1];
      hcnt_q   <= hcnt_d;
      pcnt_q   <= pcnt_d;
      oph_q    <= oph_d;
      opp_q    <= opp_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      high_q   <= high_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
`ifdef PWM_CAPTURE_TIMEOUT_EN
      tcnt_q   <= tcnt_d;
      sh_q     <= sh_d;
      sl_q     <= sl_d;
`endif
    end
  end

  // Next state: measurement FSM, one restoring-divide step per cycle, stuck handling, enable override
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    pcnt_d   = pcnt_q;
    oph_d    = oph_q;
    opp_d    = opp_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    step_d   = step_q;
    busy_d   = busy_q;
    high_d   = high_q;
    period_d = period_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    if (busy_q) begin
      rem_d  = ge ? rem2 - {1'b0, opp_q} : rem2;
      quo_d  = {quo_q[6:0], ge};
      step_d = step_q + 3'd1;
      if (step_q == 3'd7) begin
        busy_d   = 1'b0;
        high_d   = oph_q;
        period_d = opp_q;
        duty_d   = {quo_q[6:0], ge};
        valid_d  = 1'b1;
      end
    end
    case (state_q)
      IDLE: state_d = SYNC;
      SYNC: if (rise) begin
        hcnt_d  = ONE;
        pcnt_d  = ONE;
        state_d = HIGH;
      end
      HIGH: begin
        pcnt_d  = sat_inc(pcnt_q);
        hcnt_d  = fall ? hcnt_q : sat_inc(hcnt_q);
        state_d = fall ? LOW : HIGH;
      end
      LOW: if (rise) begin
        if (!busy_q) begin
          oph_d  = hcnt_q;
          opp_d  = pcnt_q;
          rem_d  = {1'b0, hcnt_q};
          quo_d  = '0;
          step_d = '0;
          busy_d = 1'b1;
        end
        hcnt_d  = ONE;
        pcnt_d  = ONE;
        state_d = HIGH;
      end else pcnt_d = sat_inc(pcnt_q);
    endcase
`ifdef PWM_CAPTURE_TIMEOUT_EN
    tcnt_d = (state_q == IDLE) ? '0 : (rise | fall) ? T_W'(1) :
             (tcnt_q == T_W'(TIMEOUT)) ? tcnt_q : tcnt_q + T_W'(1);
    sh_d   = (rise | fall) ? 1'b0 : sh_q;
    sl_d   = (rise | fall) ? 1'b0 : sl_q;
    hit    = !(rise | fall) && state_q != IDLE && tcnt_q == T_W'(TIMEOUT - 1) && !sh_q && !sl_q;
    if (hit && (sync_q[1] ? state_q != LOW : state_q != HIGH)) begin
      sh_d     = sync_q[1];
      sl_d     = ~sync_q[1];
      duty_d   = {8{sync_q[1]}};
      high_d   = '0;
      period_d = '0;
      valid_d  = 1'b1;
      busy_d   = 1'b0;
      state_d  = SYNC;
    end
`endif
    if (!enable) begin
      state_d  = IDLE;
      hcnt_d   = '0;
      pcnt_d   = '0;
      busy_d   = 1'b0;
      valid_d  = 1'b0;
      high_d   = high_q;
      period_d = period_q;
      duty_d   = duty_q;
`ifdef PWM_CAPTURE_TIMEOUT_EN
      sh_d     = 1'b0;
      sl_d     = 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized PWM stimulus checked against a period-level reference model
module tb_pwm_capture;
  logic clk = 0, rst = 1, pwm_in = 0, enable = 0;
  logic [15:0] high_cnt, period_cnt;
  logic [7:0] duty;
  logic valid;
`ifdef PWM_CAPTURE_TIMEOUT_EN
  logic stuck_high, stuck_low;
`endif
  int checks = 0, errors = 0, cyc = 0;
  typedef struct packed {int t; logic [15:0] h; logic [15:0] p; logic [7:0] d;} ev_t;
  ev_t got[$], exp[$];
  int rises[$], highs[$];

  pwm_capture dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .enable(enable),
    .high_cnt(high_cnt), .period_cnt(period_cnt), .duty(duty), .valid(valid)
`ifdef PWM_CAPTURE_TIMEOUT_EN
    , .stuck_high(stuck_high), .stuck_low(stuck_low)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid) got.push_back('{cyc, high_cnt, period_cnt, duty});

  // Reference: each rise closes the previous period; the divider is free again 9 cycles after
  // the accepted close; the result appears 2 (synchronizer) + 9 cycles after pwm_in rises.
  task automatic build_exp();
    int last = -1000;
    exp.delete();
    for (int i = 1; i < rises.size(); i++) if (rises[i] - last >= 9) begin
      int p = rises[i] - rises[i-1];
      last = rises[i];
      exp.push_back('{rises[i] + 11, 16'(highs[i-1]), 16'(p), 8'((highs[i-1] * 256) / p)});
    end
  endtask

  task automatic begin_run();
    @(posedge clk); #1;
    enable = 0; pwm_in = 0;
    repeat (4) @(posedge clk); #1;
    enable = 1;
    repeat (4) @(posedge clk); #1;
    got.delete(); rises.delete(); highs.delete();
  endtask

  task automatic seg(input int h, input int l);
    pwm_in = 1; rises.push_back(cyc); highs.push_back(h);
    repeat (h) @(posedge clk); #1;
    pwm_in = 0;
    repeat (l) @(posedge clk); #1;
  endtask

  task automatic close_run();
    pwm_in = 1; rises.push_back(cyc); highs.push_back(0);
    repeat (20) @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({high_cnt, period_cnt, duty, valid} !== 41'd0) begin
      errors++; $display("FAIL reset got h=%0d p=%0d d=%0d v=%0b want 0", high_cnt, period_cnt, duty, valid);
    end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_pattern(input string nm, input int h, input int l, input int n);
    begin_run();
    for (int i = 0; i < n; i++) seg(h, l);
    close_run();
    build_exp();
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL %s count got %0d want %0d", nm, got.size(), exp.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s ev%0d got t=%0d h=%0d p=%0d d=%0d want t=%0d h=%0d p=%0d d=%0d", nm, i,
                 got[i].t, got[i].h, got[i].p, got[i].d, exp[i].t, exp[i].h, exp[i].p, exp[i].d);
      end
    end
  endtask

  task automatic test_random();
    begin_run();
    for (int i = 0; i < 12; i++) seg($urandom_range(40, 1), $urandom_range(40, 1));
    close_run();
    build_exp();
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL random count got %0d want %0d", got.size(), exp.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL random ev%0d got t=%0d h=%0d p=%0d d=%0d want t=%0d h=%0d p=%0d d=%0d", i,
                 got[i].t, got[i].h, got[i].p, got[i].d, exp[i].t, exp[i].h, exp[i].p, exp[i].d);
      end
    end
  endtask

  task automatic test_reset_mid();
    begin_run();
    seg(64, 192); seg(64, 192);
    pwm_in = 1;
    repeat (30) @(posedge clk); #1;
    checks++;
    if (high_cnt !== 16'd64) begin errors++; $display("FAIL pre_rst high got %0d want 64", high_cnt); end
    #2 rst = 1;
    #1;
    checks++;
    if ({high_cnt, period_cnt, duty, valid} !== 41'd0) begin
      errors++; $display("FAIL async_rst got h=%0d p=%0d d=%0d v=%0b want 0", high_cnt, period_cnt, duty, valid);
    end
    @(posedge clk); #1;
    rst = 0; pwm_in = 0;
    repeat (4) @(posedge clk); #1;
    got.delete(); rises.delete(); highs.delete();
    seg(64, 192); seg(64, 192);
    close_run();
    build_exp();
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL rst_mid count got %0d want %0d", got.size(), exp.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL rst_mid ev%0d got t=%0d h=%0d p=%0d d=%0d want t=%0d h=%0d p=%0d d=%0d", i,
                 got[i].t, got[i].h, got[i].p, got[i].d, exp[i].t, exp[i].h, exp[i].p, exp[i].d);
      end
    end
  endtask

  task automatic test_enable_drop();
    begin_run();
    seg(30, 20); seg(30, 5);
    repeat (3) @(posedge clk); #1;
    enable = 0;
    repeat (10) @(posedge clk); #1;
    pwm_in = 1;
    repeat (40) @(posedge clk); #1;
    build_exp();
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL en_drop count got %0d want %0d", got.size(), exp.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL en_drop ev%0d got t=%0d h=%0d p=%0d d=%0d want t=%0d h=%0d p=%0d d=%0d", i,
                 got[i].t, got[i].h, got[i].p, got[i].d, exp[i].t, exp[i].h, exp[i].p, exp[i].d);
      end
    end
    begin_run();
    seg(25, 25); seg(25, 25);
    close_run();
    build_exp();
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL re_en count got %0d want %0d", got.size(), exp.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL re_en ev%0d got t=%0d h=%0d p=%0d d=%0d want t=%0d h=%0d p=%0d d=%0d", i,
                 got[i].t, got[i].h, got[i].p, got[i].d, exp[i].t, exp[i].h, exp[i].p, exp[i].d);
      end
    end
  endtask

`ifdef PWM_CAPTURE_TIMEOUT_EN
  task automatic test_stuck(input logic lvl);
    int n = 0;
    begin_run();
    pwm_in = lvl;
    while ((lvl ? stuck_high : stuck_low) !== 1'b1 && n < 1200) begin @(negedge clk); n++; end
    repeat (300) @(negedge clk);
    checks++;
    if ((lvl ? stuck_high : stuck_low) !== 1'b1) begin errors++; $display("FAIL stuck%0b flag got 0 want 1", lvl); end
    checks++;
    if (got.size() != 1) begin errors++; $display("FAIL stuck%0b valids got %0d want 1", lvl, got.size()); end
    else begin
      checks++;
      if ({got[0].h, got[0].p, got[0].d} !== {16'd0, 16'd0, {8{lvl}}}) begin
        errors++; $display("FAIL stuck%0b out got h=%0d p=%0d d=%0d want h=0 p=0 d=%0d", lvl, got[0].h, got[0].p, got[0].d, lvl ? 255 : 0);
      end
    end
    @(posedge clk); #1 pwm_in = ~lvl;
    repeat (5) @(negedge clk);
    checks++;
    if ({stuck_high, stuck_low} !== 2'b00) begin errors++; $display("FAIL stuck%0b clear got %b want 00", lvl, {stuck_high, stuck_low}); end
  endtask
`else
  task automatic test_static();
    begin_run();
    repeat (1500) @(posedge clk); #1;
    pwm_in = 1;
    repeat (1500) @(posedge clk); #1;
    checks++;
    if (got.size() != 0) begin errors++; $display("FAIL static valids got %0d want 0", got.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_pattern("duty64", 64, 192, 4);
    test_pattern("duty255", 255, 1, 3);
    test_pattern("fast3_2", 3, 2, 8);
    test_pattern("duty1", 1, 255, 2);
    test_random();
    test_random();
    test_reset_mid();
    test_enable_drop();
`ifdef PWM_CAPTURE_TIMEOUT_EN
    test_stuck(1'b0);
    test_stuck(1'b1);
`else
    test_static();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the high-time and period counters.
REQ-002 SHALL have parameter TIMEOUT, default 1023: the stuck-detect limit, in clk cycles (used only with PWM_CAPTURE_TIMEOUT_EN).
REQ-003 SHALL have port clk  in  1: single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-005 SHALL have port pwm_in  in  1: PWM input, asynchronous to clk.
REQ-006 SHALL have port enable  in  1: measurement enable.
REQ-007 SHALL have port high_cnt  out  CNT_W: measured high time, in cycles.
REQ-008 SHALL have port period_cnt  out  CNT_W: measured period, in cycles.
REQ-009 SHALL have port duty  out  8: floor(high_cnt*256/period_cnt).
REQ-010 SHALL have port valid  out  1: one-cycle pulse when the outputs update.
REQ-011 SHALL have ports stuck_high and stuck_low  out  1 each: level flags (present only with the macro).

Function
REQ-012 SHALL pass pwm_in through a 2-flop synchronizer; rise/fall SHALL be detected from the synchronized signal versus its 1-cycle-delayed copy.
REQ-013 SHALL implement states IDLE, SYNC, HIGH, LOW; enable=0 in any state SHALL force IDLE and clear the counters.
REQ-014 IDLE->SYNC when enable=1; SYNC waits for a rise and ignores a pwm_in that is already high.
REQ-015 On a rise detected in SYNC or LOW, the block SHALL load pcnt=1 and hcnt=1, then go to HIGH.
REQ-016 In HIGH, each cycle without a fall SHALL increment hcnt and pcnt; on a fall it SHALL increment pcnt only, then go to LOW.
REQ-017 In LOW, each cycle without a rise SHALL increment pcnt.
REQ-018 A rise in LOW SHALL close the period: hcnt/pcnt are latched into the divider operands in that cycle (call it R), then REQ-015 applies.
REQ-019 Counters SHALL saturate at all-ones and never wrap.
REQ-020 Divider SHALL be 8-step restoring: rem=high; each step rem=2*rem; if rem>=period then bit=1 and rem-=period. rem width SHALL be CNT_W+1.
REQ-021 Divider SHALL run cycles R+1..R+8; high_cnt, period_cnt and duty SHALL update, and valid SHALL pulse, at R+9.
REQ-022 A period closing while the divider is busy SHALL be dropped with no output change; measurement SHALL continue.
REQ-023 For a generator of period 256 with duty d in 1..255, the block SHALL report high_cnt=d, period_cnt=256, duty=d.
REQ-024 A first partial period after enable/reset SHALL never produce valid.

Reset
REQ-025 On rst=1, state SHALL go to IDLE; synchronizer, counters, divider, high_cnt, period_cnt, duty, valid, stuck_high and stuck_low SHALL all be 0, immediately and asynchronously.
REQ-026 Reset mid-measurement or mid-division SHALL discard the partial result; no valid SHALL be produced for it.

Configuration
REQ-027 Macro PWM_CAPTURE_TIMEOUT_EN, when defined, SHALL enable stuck detection and the stuck_high/stuck_low ports.
REQ-028 With the macro: synchronized input high for TIMEOUT consecutive cycles (in SYNC or HIGH) SHALL set stuck_high=1, duty=255, high_cnt=period_cnt=0, pulse valid once, and return to SYNC.
REQ-029 With the macro: synchronized input low for TIMEOUT consecutive cycles (in SYNC or LOW) SHALL set stuck_low=1, duty=0, high_cnt=period_cnt=0, pulse valid once, and return to SYNC.
REQ-030 A stuck flag SHALL persist until the next detected edge or until enable=0; no repeat valid SHALL occur while the flag is set.
REQ-031 Without the macro: no stuck ports, no timeout logic; a static input SHALL produce no valid.

Verification
REQ-032 Bench SHALL cover: period 256, high 64 -> every period after the first full one: high_cnt=64, period_cnt=256, duty=64, valid 9 cycles after the closing rise detect.
REQ-033 Bench SHALL cover: period 256, high 255 -> high_cnt=255, period_cnt=256, duty=255.
REQ-034 Bench SHALL cover: high 3, low 2 (period 5) -> high_cnt=3, period_cnt=5, duty=153; valid every 10 cycles, alternate periods dropped.
REQ-035 Bench SHALL cover: macro on, TIMEOUT=1023, pwm_in held 0 after enable -> stuck_low=1, duty=0, single valid; the next rise clears stuck_low.
REQ-036 Bench SHALL cover: rst pulsed mid-HIGH at duty 64 -> all outputs 0 at once; first valid only after a full new period.
REQ-037 Bench SHALL cover: enable dropped in LOW -> IDLE, no valid; re-enable -> first valid after two rises plus 9 cycles.
